tx_arbiter: RTL and testbench

Shares the single UART transmit channel among `N_SRC` reply sources; it is the return-path counterpart of the command decoder. Each source owns a show-ahead byte FIFO. The arbiter picks one non-empty FIFO round-robin and frames its pending bytes as PREFIX, SRC, LEN, DATA…, CRC, using the same frame format the host sends downstream. It drives the UART transmitter through a valid/ready byte handshake.

---
 rtl/tx_arbiter_pkg.sv | 28 ++
 rtl/tx_arbiter_rr_select.sv | 30 +++
 rtl/tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for tx_arbiter: frame prefix, default source count and FSM encoding.
// The optional CRC trailer byte is selected by defining TX_CRC_EN.
`ifndef PREFIX
`define PREFIX 8'hA5
`endif
`ifndef N_SRC
`define N_SRC 4
`endif

package tx_arbiter_pkg;

    localparam logic [7:0]  PrefixByte  = `PREFIX;
    localparam int unsigned NSrcDefault = `N_SRC;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StSendPrefix = 3'd1,
        StSendSrc    = 3'd2,
        StSendLen    = 3'd3,
        StSendData   = 3'd4,
        StSendCrc    = 3'd5
    } tx_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_select.sv
// Combinational round-robin first-one search: lowest-priority position is last_i,
// the search starts at last_i+1 and wraps modulo NSrc.
module tx_arbiter_rr_select
    import tx_arbiter_pkg::*;
#(
    parameter int unsigned NSrc = NSrcDefault,
    parameter int unsigned IdxW = idx_width(NSrc)
) (
    input  logic [NSrc-1:0] req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [IdxW-1:0] grant_o,
    output logic            found_o
);

    int unsigned idx;

    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= NSrc; k++) begin
            idx = (32'(last_i) + k) % NSrc;
            if (!found_o && req_i[idx]) begin
                found_o = 1'b1;
                grant_o = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin return-path arbiter: frames one source FIFO at a time as
// PREFIX, SRC, LEN, DATA..., [CRC] onto a valid/ready byte channel. CRC byte only with TX_CRC_EN.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int unsigned NSrc   = NSrcDefault,
    parameter int unsigned MaxLen = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NSrc-1:0]   src_empty_i,
    input  logic [8*NSrc-1:0] src_usedw_i,
    input  logic [8*NSrc-1:0] src_q_i,
    output logic [NSrc-1:0]   src_rdreq_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o
);

    localparam int unsigned IdxW    = idx_width(NSrc);
    localparam logic [8:0]  MaxLenW = 9'(MaxLen);

    tx_state_e       state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      cnt_q, cnt_d;
`ifdef TX_CRC_EN
    logic [7:0]      crc_q, crc_d;
`endif

    logic [IdxW-1:0] rr_grant;
    logic            rr_found;
    logic [7:0]      sel_usedw;
    logic [8:0]      sel_fill;
    logic [7:0]      new_len;
    logic [7:0]      head_byte;
    logic            xfer;

    tx_arbiter_rr_select #(
        .NSrc (NSrc),
        .IdxW (IdxW)
    ) u_rr_select (
        .req_i   (~src_empty_i),
        .last_i  (last_q),
        .grant_o (rr_grant),
        .found_o (rr_found)
    );

    // usedw wraps to 0 when the FIFO holds 256 bytes
    assign sel_usedw = src_usedw_i[32'(rr_grant)*8 +: 8];
    assign sel_fill  = (sel_usedw == 8'd0) ? 9'd256 : {1'b0, sel_usedw};
    assign new_len   = (sel_fill > MaxLenW) ? MaxLenW[7:0] : sel_fill[7:0];
    assign head_byte = src_q_i[32'(grant_q)*8 +: 8];
    assign xfer      = tx_valid_o & tx_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IdxW'(NSrc - 1);
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
`ifdef TX_CRC_EN
            crc_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
`ifdef TX_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
`ifdef TX_CRC_EN
        crc_d   = crc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    grant_d = rr_grant;
                    last_d  = rr_grant;
                    len_d   = new_len;
                    cnt_d   = new_len;
`ifdef TX_CRC_EN
                    crc_d   = 8'(rr_grant) + new_len;
`endif
                    state_d = StSendPrefix;
                end
            end
            StSendPrefix: if (xfer) state_d = StSendSrc;
            StSendSrc:    if (xfer) state_d = StSendLen;
            StSendLen:    if (xfer) state_d = StSendData;
            StSendData: begin
                if (xfer) begin
                    cnt_d = cnt_q - 8'd1;
`ifdef TX_CRC_EN
                    crc_d = crc_q + head_byte;
                    if (cnt_q == 8'd1) state_d = StSendCrc;
`else
                    if (cnt_q == 8'd1) state_d = StIdle;
`endif
                end
            end
`ifdef TX_CRC_EN
            StSendCrc:    if (xfer) state_d = StIdle;
`endif
            default:      state_d = StIdle;
        endcase
    end

    // Outputs decode from registered state only, so reset clears them without a clock
    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'd0;
        src_rdreq_o = '0;
        busy_o      = (state_q != StIdle);
        unique case (state_q)
            StIdle: ;
            StSendPrefix: begin
                tx_valid_o = 1'b1;
                tx_data_o  = PrefixByte;
            end
            StSendSrc: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'(grant_q);
            end
            StSendLen: begin
                tx_valid_o = 1'b1;
                tx_data_o  = len_q;
            end
            StSendData: begin
                tx_valid_o           = 1'b1;
                tx_data_o            = head_byte;
                src_rdreq_o[grant_q] = tx_ready_i;
            end
`ifdef TX_CRC_EN
            StSendCrc: begin
                tx_valid_o = 1'b1;
                tx_data_o  = crc_q;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter with behavioural show-ahead FIFOs per source.
module tb_tx_arbiter;
    import tx_arbiter_pkg::*;

    localparam int NS = 4;
`ifdef TX_CRC_EN
    localparam int CrcBytes = 1;
`else
    localparam int CrcBytes = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NS-1:0]   src_empty, src_rdreq;
    logic [8*NS-1:0] src_usedw, src_q;
    logic [7:0]      tx_data;
    logic            tx_valid, busy;
    logic            tx_ready = 1'b1;

    always #5 clk = ~clk;

    tx_arbiter #(
        .NSrc   (NS),
        .MaxLen (255)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .src_empty_i (src_empty),
        .src_usedw_i (src_usedw),
        .src_q_i     (src_q),
        .src_rdreq_o (src_rdreq),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .busy_o      (busy)
    );

    bit [7:0] mem [NS][1024];
    int wr_ptr [NS];
    int rd_ptr [NS];
    int pop_cnt [NS];
    int bad_pop, stall_viol, idle_run, busy_cyc;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic [7:0] cap [$];
    logic [7:0] exp_q [$];
    int gaps [$];
    int n_checks = 0;
    int n_fail = 0;

    always_comb begin
        src_empty = '1;
        src_usedw = '0;
        src_q     = '0;
        for (int s = 0; s < NS; s++) begin
            src_empty[s]       = (wr_ptr[s] == rd_ptr[s]);
            src_usedw[8*s +: 8] = 8'(wr_ptr[s] - rd_ptr[s]);
            src_q[8*s +: 8]     = mem[s][rd_ptr[s] % 1024];
        end
    end

    always @(posedge clk) begin
        for (int s = 0; s < NS; s++) begin
            if (src_rdreq[s]) begin
                rd_ptr[s]  <= rd_ptr[s] + 1;
                pop_cnt[s] <= pop_cnt[s] + 1;
                if (wr_ptr[s] == rd_ptr[s]) bad_pop <= bad_pop + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_valid && tx_ready) cap.push_back(tx_data);
        if (busy) begin
            if (idle_run > 0) gaps.push_back(idle_run);
            idle_run <= 0;
            busy_cyc <= busy_cyc + 1;
        end else begin
            idle_run <= idle_run + 1;
        end
        stall_viol <= stall_viol + int'(prev_stall && tx_valid && tx_data != prev_data)
                                 + int'(src_rdreq != '0 && !tx_ready);
        prev_stall <= tx_valid && !tx_ready && rst_n;
        prev_data  <= tx_data;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int src, input int n, input logic [7:0] b0, input logic [7:0] step);
        for (int i = 0; i < n; i++) begin
            mem[src][wr_ptr[src] % 1024] = b0 + 8'(i) * step;
            wr_ptr[src]++;
        end
    endtask

    task automatic add_frame(input int src, input int n, input logic [7:0] b0,
                             input logic [7:0] step);
        logic [7:0] crc;
        crc = 8'(src) + 8'(n);
        exp_q.push_back(PrefixByte);
        exp_q.push_back(8'(src));
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(b0 + 8'(i) * step);
            crc = crc + b0 + 8'(i) * step;
        end
        if (CrcBytes == 1) exp_q.push_back(crc);
    endtask

    task automatic check_stream(input string tag, input int base);
        int w = 0;
        int got;
        while (cap.size() < base + exp_q.size() && w < 3000) begin
            @(posedge clk);
            w++;
        end
        repeat (12) @(posedge clk);
        check_eq({tag, "_count"}, cap.size() - base, exp_q.size());
        foreach (exp_q[i]) begin
            got = (base + i < cap.size()) ? int'(cap[base + i]) : -1;
            check_eq($sformatf("%s_b%0d", tag, i), got, int'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        #2;
        tx_ready = 1'b1;
        rst_n    = 1'b0;
        #1;
        check_eq("rst_valid", int'(tx_valid), 0);
        check_eq("rst_data", int'(tx_data), 0);
        check_eq("rst_rdreq", int'(src_rdreq), 0);
        check_eq("rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [15:0] pat = 16'b1001_0110_0011_1010;
    int base, p0, bc0, g0, sv0, w;

    initial begin
        // 1: single frame from source 2
        do_reset();
        base = cap.size(); p0 = pop_cnt[2]; bc0 = busy_cyc;
        @(posedge clk); #1;
        fill(2, 3, 8'h11, 8'h11);
        add_frame(2, 3, 8'h11, 8'h11);
        check_stream("s1", base);
        check_eq("s1_pops", pop_cnt[2] - p0, 3);
`ifdef TX_CRC_EN
        check_eq("s1_crc", (cap.size() > base + 6) ? int'(cap[base + 6]) : -1, 'h6B);
        check_eq("s1_busy_cycles", busy_cyc - bc0, 7);
`else
        check_eq("s1_bytes", cap.size() - base, 6);
        check_eq("s1_busy_cycles", busy_cyc - bc0, 6);
`endif

        // 2: round robin 0, 3, then refilled 0
        do_reset();
        base = cap.size(); g0 = gaps.size();
        @(posedge clk); #1;
        fill(0, 1, 8'hA0, 8'h00);
        fill(3, 1, 8'hB3, 8'h00);
        w = 0;
        while (cap.size() < base + 2 * (4 + CrcBytes) && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        w = 0;
        while (busy && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        fill(0, 1, 8'hA1, 8'h00);
        add_frame(0, 1, 8'hA0, 8'h00);
        add_frame(3, 1, 8'hB3, 8'h00);
        add_frame(0, 1, 8'hA1, 8'h00);
        check_stream("s2", base);
        check_eq("s2_gap", (gaps.size() > g0 + 1) ? gaps[g0 + 1] : -1, 1);

        // 3: back-pressure during the frame
        do_reset();
        base = cap.size(); p0 = pop_cnt[1]; sv0 = stall_viol;
        @(posedge clk); #1;
        fill(1, 5, 8'h90, 8'h03);
        add_frame(1, 5, 8'h90, 8'h03);
        for (int i = 0; i < 200 && cap.size() < base + 9 + CrcBytes; i++) begin
            @(posedge clk); #1;
            tx_ready = pat[i % 16];
        end
        tx_ready = 1'b1;
        check_stream("s3", base);
        check_eq("s3_pops", pop_cnt[1] - p0, 5);
        check_eq("s3_stall", stall_viol - sv0, 0);

        // 4: bytes pushed mid-frame go into the next frame
        do_reset();
        base = cap.size();
        @(posedge clk); #1;
        fill(1, 2, 8'h41, 8'h01);
        w = 0;
        while (!busy && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check_eq("s4_granted", int'(busy), 1);
        fill(1, 2, 8'h43, 8'h01);
        add_frame(1, 2, 8'h41, 8'h01);
        add_frame(1, 2, 8'h43, 8'h01);
        check_stream("s4", base);

        // 5: full FIFO split at MaxLen, source 2 interleaved
        do_reset();
        base = cap.size(); p0 = pop_cnt[0];
        @(posedge clk); #1;
        fill(0, 256, 8'h00, 8'h01);
        fill(2, 1, 8'hC2, 8'h00);
        add_frame(0, 255, 8'h00, 8'h01);
        add_frame(2, 1, 8'hC2, 8'h00);
        add_frame(0, 1, 8'hFF, 8'h00);
        check_stream("s5", base);
        check_eq("s5_pops", pop_cnt[0] - p0, 256);

        // 6: asynchronous reset during the second data byte
        do_reset();
        base = cap.size();
        @(posedge clk); #1;
        fill(0, 3, 8'h61, 8'h01);
        fill(1, 1, 8'h71, 8'h00);
        w = 0;
        while (cap.size() < base + 4 && w < 50) begin
            @(posedge clk);
            w++;
        end
        #2;
        check_eq("s6_data1", int'(tx_data), 'h62);
        rst_n = 1'b0;
        #1;
        check_eq("s6_async_valid", int'(tx_valid), 0);
        check_eq("s6_async_rdreq", int'(src_rdreq), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.push_back(PrefixByte);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h61);
        add_frame(0, 2, 8'h62, 8'h01);
        add_frame(1, 1, 8'h71, 8'h00);
        check_stream("s6", base);

        check_eq("bad_pop", bad_pop, 0);
        check_eq("stall_total", stall_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
